// File: rtl/mul_result_collector.sv
// Result collector for the 5-stage pipelined multiplier: credit-gated result FIFO drained over valid/ready.
// Optional macro MUL_RESULT_BYPASS_EN adds a 0-cycle path from res_* to wb_* when the FIFO is empty.
module mul_result_collector #(
    parameter int ARCH_LEN = 32,
    parameter int DEPTH    = 4,
    parameter int TAG_W    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          issue_valid,
    output logic                          credit_avail,
    input  logic                          res_valid,
    input  logic [TAG_W-1:0]              res_tag,
    input  logic [4:0]                    res_dst_reg,
    input  logic                          res_hi_sel,
    input  logic [2*ARCH_LEN-1:0]         res_data,
    output logic                          wb_valid,
    input  logic                          wb_ready,
    output logic [TAG_W-1:0]              wb_tag,
    output logic [4:0]                    wb_dst_reg,
    output logic [ARCH_LEN-1:0]           wb_data,
    output logic [$clog2(DEPTH):0]        occupancy,
    output logic                          err_overflow,
    output logic                          err_orphan
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [TAG_W-1:0]    tag_mem  [DEPTH];
    logic [4:0]          dst_mem  [DEPTH];
    logic [ARCH_LEN-1:0] data_mem [DEPTH];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] inflight;
    logic             overflow_flag;
    logic             orphan_flag;

    logic [ARCH_LEN-1:0] res_half;
    logic [CNT_W:0]      committed;
    logic                fifo_empty;
    logic                fifo_full;
    logic                legal_issue;
    logic                bad_issue;
    logic                push_req;
    logic                bypass_take;
    logic                pop;
    logic                push;
    logic                push_drop;

    assign res_half   = res_hi_sel ? res_data[2*ARCH_LEN-1:ARCH_LEN] : res_data[ARCH_LEN-1:0];
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_W'(DEPTH));

    // Every in-flight multiply reserves a FIFO slot, so issue only while slots remain unreserved.
    assign committed    = {1'b0, count} + {1'b0, inflight};
    assign credit_avail = (committed < (CNT_W+1)'(DEPTH));
    assign legal_issue  = issue_valid && credit_avail;
    assign bad_issue    = issue_valid && !credit_avail;

    assign push_req = res_valid && (res_dst_reg != 5'd0);

`ifdef MUL_RESULT_BYPASS_EN
    assign bypass_take = fifo_empty && push_req && wb_ready;
`else
    assign bypass_take = 1'b0;
`endif

    assign pop       = !fifo_empty && wb_ready;
    assign push      = push_req && !bypass_take && (!fifo_full || pop);
    assign push_drop = push_req && fifo_full && !pop;

    always_comb begin
        wb_valid   = 1'b0;
        wb_tag     = '0;
        wb_dst_reg = '0;
        wb_data    = '0;
        if (!fifo_empty) begin
            wb_valid   = 1'b1;
            wb_tag     = tag_mem[rd_ptr];
            wb_dst_reg = dst_mem[rd_ptr];
            wb_data    = data_mem[rd_ptr];
        end
`ifdef MUL_RESULT_BYPASS_EN
        else if (push_req) begin
            wb_valid   = 1'b1;
            wb_tag     = res_tag;
            wb_dst_reg = res_dst_reg;
            wb_data    = res_half;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr]  <= res_tag;
            dst_mem[wr_ptr]  <= res_dst_reg;
            data_mem[wr_ptr] <= res_half;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            inflight      <= '0;
            overflow_flag <= 1'b0;
            orphan_flag   <= 1'b0;
        end else begin
            // Pointers wrap on their own because DEPTH is a power of two.
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);

            // A completion with nothing outstanding must not underflow the counter.
            if (legal_issue && !res_valid)
                inflight <= inflight + 1'b1;
            else if (!legal_issue && res_valid && (inflight != '0))
                inflight <= inflight - 1'b1;

            if (bad_issue || push_drop)
                overflow_flag <= 1'b1;
            if (res_valid && (inflight == '0))
                orphan_flag <= 1'b1;
        end
    end

    assign occupancy    = count;
    assign err_overflow = overflow_flag;
    assign err_orphan   = orphan_flag;

endmodule

// File: tb/tb_mul_result_collector.sv
// Bench for mul_result_collector: queue-based reference model checked every cycle, directed scenarios, random traffic.
module tb_mul_result_collector;
    localparam int ARCH_LEN = 32;
    localparam int DEPTH    = 4;
    localparam int TAG_W    = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic        credit_avail;
    logic        res_valid;
    logic [3:0]  res_tag;
    logic [4:0]  res_dst_reg;
    logic        res_hi_sel;
    logic [63:0] res_data;
    logic        wb_valid;
    logic        wb_ready;
    logic [3:0]  wb_tag;
    logic [4:0]  wb_dst_reg;
    logic [31:0] wb_data;
    logic [2:0]  occupancy;
    logic        err_overflow;
    logic        err_orphan;

    mul_result_collector #(.ARCH_LEN(ARCH_LEN), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .credit_avail(credit_avail),
        .res_valid(res_valid), .res_tag(res_tag), .res_dst_reg(res_dst_reg),
        .res_hi_sel(res_hi_sel), .res_data(res_data), .wb_valid(wb_valid),
        .wb_ready(wb_ready), .wb_tag(wb_tag), .wb_dst_reg(wb_dst_reg), .wb_data(wb_data),
        .occupancy(occupancy), .err_overflow(err_overflow), .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  tag;
        logic [4:0]  dst;
        logic [31:0] data;
    } entry_t;

    entry_t q[$];
    int     m_inflight;
    bit     m_ovf;
    bit     m_orph;
    int     checks = 0;
    int     errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_inflight = 0;
        m_ovf      = 1'b0;
        m_orph     = 1'b0;
    endtask

    task automatic compare_model();
        logic        e_valid;
        logic [3:0]  e_tag;
        logic [4:0]  e_dst;
        logic [31:0] e_data;
        int          credits;
        credits = DEPTH - q.size() - m_inflight;
        e_valid = 1'b0;
        e_tag   = '0;
        e_dst   = '0;
        e_data  = '0;
        if (q.size() > 0) begin
            e_valid = 1'b1;
            e_tag   = q[0].tag;
            e_dst   = q[0].dst;
            e_data  = q[0].data;
        end
`ifdef MUL_RESULT_BYPASS_EN
        else if (res_valid && res_dst_reg != 5'd0) begin
            e_valid = 1'b1;
            e_tag   = res_tag;
            e_dst   = res_dst_reg;
            e_data  = res_hi_sel ? res_data[63:32] : res_data[31:0];
        end
`endif
        chk("credit_avail", 64'(credit_avail), 64'(credits > 0));
        chk("occupancy", 64'(occupancy), 64'(q.size()));
        chk("wb_valid", 64'(wb_valid), 64'(e_valid));
        if (e_valid) begin
            chk("wb_tag", 64'(wb_tag), 64'(e_tag));
            chk("wb_dst_reg", 64'(wb_dst_reg), 64'(e_dst));
            chk("wb_data", 64'(wb_data), 64'(e_data));
        end
        chk("err_overflow", 64'(err_overflow), 64'(m_ovf));
        chk("err_orphan", 64'(err_orphan), 64'(m_orph));
    endtask

    // Applies the inputs the DUT is about to sample on the coming rising edge.
    task automatic model_step();
        bit     credit;
        bit     legal;
        bit     pop;
        int     size_before;
        entry_t e;
        size_before = q.size();
        credit = (DEPTH - size_before - m_inflight) > 0;
        legal  = issue_valid && credit;
        pop    = (size_before > 0) && wb_ready;
        if (issue_valid && !credit) m_ovf = 1'b1;
        if (res_valid && m_inflight == 0) m_orph = 1'b1;
        if (legal && !res_valid) m_inflight++;
        else if (!legal && res_valid && m_inflight > 0) m_inflight--;
        e.tag  = res_tag;
        e.dst  = res_dst_reg;
        e.data = res_hi_sel ? res_data[63:32] : res_data[31:0];
        if (pop) void'(q.pop_front());
        if (res_valid && res_dst_reg != 5'd0) begin
`ifdef MUL_RESULT_BYPASS_EN
            if (size_before == 0 && wb_ready) begin
            end else
`endif
            if (size_before == DEPTH && !pop) m_ovf = 1'b1;
            else q.push_back(e);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (!rst) model_reset();
        compare_model();
        if (rst) model_step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic put_res(input logic [3:0] tag, input logic [4:0] dst, input logic hi, input logic [63:0] data);
        res_valid   = 1'b1;
        res_tag     = tag;
        res_dst_reg = dst;
        res_hi_sel  = hi;
        res_data    = data;
        step();
        res_valid   = 1'b0;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic issue_n(input int n);
        issue_valid = 1'b1;
        for (int i = 0; i < n; i++) step();
        issue_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; issue_valid = 1'b0; res_valid = 1'b0; res_tag = '0;
        res_dst_reg = '0; res_hi_sel = 1'b0; res_data = '0; wb_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        chk("reset credit_avail", 64'(credit_avail), 64'd1);
        chk("reset wb_valid", 64'(wb_valid), 64'd0);
        chk("reset occupancy", 64'(occupancy), 64'd0);
        chk("reset flags", 64'({err_overflow, err_orphan}), 64'd0);
        chk("reset wb_data", 64'(wb_data), 64'd0);
        rst = 1'b1;
        step();

        // Credits exhaust after DEPTH issues; one more is an overflow.
        issue_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("credit before issue", 64'(credit_avail), 64'd1);
            step();
        end
        chk("credit after 4 issues", 64'(credit_avail), 64'd0);
        step();
        issue_valid = 1'b0;
        chk("overflow on 5th issue", 64'(err_overflow), 64'd1);
        do_reset();

        // Low half, then high half of the same product.
        wb_ready = 1'b1;
        for (int h = 0; h < 2; h++) begin
            issue_n(1);
            idle(4);
            put_res(4'(2 + h), 5'd7, h[0], 64'h0000_0003_0000_0005);
`ifndef MUL_RESULT_BYPASS_EN
            chk("lit wb_valid", 64'(wb_valid), 64'd1);
            chk("lit wb_data", 64'(wb_data), (h == 0) ? 64'h5 : 64'h3);
            chk("lit wb_dst_reg", 64'(wb_dst_reg), 64'd7);
            chk("lit wb_tag", 64'(wb_tag), 64'(2 + h));
`endif
            step();
            chk("lit drained occupancy", 64'(occupancy), 64'd0);
            chk("lit credit returned", 64'(credit_avail), 64'd1);
        end

        // Fill with writeback stalled, then drain in order.
        wb_ready = 1'b0;
        issue_n(4);
        idle(2);
        for (int i = 0; i < 4; i++) put_res(4'(i), 5'(i + 1), 1'b0, {32'h0, 32'(100 + i)});
        chk("lit full occupancy", 64'(occupancy), 64'd4);
        chk("lit full credit", 64'(credit_avail), 64'd0);
        idle(3);
        wb_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("lit drain tag", 64'(wb_tag), 64'(i));
            step();
        end
        chk("lit drained", 64'(occupancy), 64'd0);

        // Full FIFO with simultaneous push and pop, then a dst_reg=0 result.
        wb_ready = 1'b0;
        issue_n(4);
        for (int i = 0; i < 4; i++) put_res(4'(8 + i), 5'd9, 1'b1, {32'(i), 32'h0});
        wb_ready = 1'b1;
        put_res(4'd12, 5'd10, 1'b0, 64'h1234);
        chk("lit push+pop occupancy", 64'(occupancy), 64'd4);
        chk("lit push+pop no overflow", 64'(err_overflow), 64'd0);
        chk("lit orphan set", 64'(err_orphan), 64'd1);
        step();
        wb_ready = 1'b0;
        chk("lit one popped", 64'(occupancy), 64'd3);
        issue_n(1);
        chk("lit no credit", 64'(credit_avail), 64'd0);
        put_res(4'd13, 5'd0, 1'b0, 64'hFFFF);
        chk("lit dst0 not pushed", 64'(occupancy), 64'd3);
        chk("lit dst0 credit back", 64'(credit_avail), 64'd1);
        idle(2);
        chk("lit orphan sticky", 64'(err_orphan), 64'd1);
        rst = 1'b0;
        #1;
        chk("lit async reset orphan", 64'(err_orphan), 64'd0);
        chk("lit async reset wb_valid", 64'(wb_valid), 64'd0);
        chk("lit async reset credit", 64'(credit_avail), 64'd1);
        step();
        rst = 1'b1;
        step();

        // Random traffic with one reset mid-stream.
        for (int i = 0; i < 3000; i++) begin
            issue_valid = ($urandom_range(0, 1) == 1);
            res_valid   = (m_inflight > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 63) == 0);
            res_tag     = 4'($urandom);
            res_dst_reg = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            res_hi_sel  = ($urandom_range(0, 1) == 1);
            res_data    = {$urandom(), $urandom()};
            wb_ready    = ((i % 200) < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
            rst         = (i != 1500);
            step();
        end
        issue_valid = 1'b0;
        res_valid   = 1'b0;
        rst         = 1'b1;
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mul_result_collector.md
Name: mul_result_collector

Overview:
- Receiving end of the 5-stage pipelined multiplier.
- Accepts the multiplier's completed results. The multiplier cannot stall, so each result is captured into a small FIFO and drained to the writeback stage over a valid/ready handshake.
- Issues credits to the issue stage so that the results of all in-flight multiplies always fit in the FIFO.

Parameters:
- ARCH_LEN, 32, architectural register width.
- DEPTH, 4, result FIFO entries (power of two, ≥2). Also the total credit pool.
- TAG_W, 4, width of the instruction tag carried with each result.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- issue_valid  in  1  a MUL-class instruction enters the multiplier this cycle; consumes one credit.
- credit_avail  out  1  issue permitted this cycle.
- res_valid  in  1  multiplier output valid.
- res_tag  in  TAG_W  tag of the completing instruction.
- res_dst_reg  in  5  destination register index.
- res_hi_sel  in  1  0 = low product half (MUL); 1 = high half (MULH*).
- res_data  in  2*ARCH_LEN  full product.
- wb_valid  out  1  head entry valid toward writeback.
- wb_ready  in  1  writeback accepts the head entry.
- wb_tag  out  TAG_W  head tag.
- wb_dst_reg  out  5  head destination register.
- wb_data  out  ARCH_LEN  head result, already half-selected.
- occupancy  out  $clog2(DEPTH)+1  FIFO entries held.
- err_overflow  out  1  sticky; a push was attempted while the FIFO was full.
- err_orphan  out  1  sticky; res_valid arrived while the in-flight count was 0.

Behaviour:
- Reset (rst low, async): FIFO empty, inflight = 0, rd/wr pointers = 0. All outputs 0 except credit_avail = 1. Reset mid-operation discards all entries and in-flight accounting immediately.
- Credit accounting:
  - credits = DEPTH − occupancy − inflight.
  - credit_avail = (credits > 0), combinational from registered state.
  - issue_valid with credit_avail = 0 is ignored for accounting and sets err_overflow.
- inflight update each cycle: +1 on a legal issue_valid, −1 on res_valid. Both together leave it unchanged. Counter width $clog2(DEPTH)+1.
- Push on res_valid:
  - Entry stored = {res_tag, res_dst_reg, res_hi_sel ? res_data[2*ARCH_LEN-1:ARCH_LEN] : res_data[ARCH_LEN-1:0]}.
  - res_dst_reg = 0: the entry is not pushed. inflight still decrements, so the credit is returned.
  - FIFO full (not popping the same cycle): entry dropped, err_overflow set.
  - inflight = 0: entry is still pushed if space is available; err_orphan set, inflight held at 0 (no underflow).
- Pop: on wb_valid && wb_ready, the head advances. Pointers wrap modulo DEPTH. Full/empty are distinguished by occupancy.
- Simultaneous push and pop:
  - Legal even when full; occupancy unchanged, no error.
  - When empty, push and pop cannot coincide unless the bypass is compiled in.
- Outputs: wb_* are registered FIFO-head outputs. Latency from res_valid to wb_valid is 1 cycle when the FIFO is empty.
- Handshake: wb_valid, once asserted, stays high and wb_* stay stable until accepted. Entries drain strictly in arrival order; the collector does no reordering.
- Error flags are cleared only by reset.

Optional Feature:
- MUL_RESULT_BYPASS_EN defined:
  - When the FIFO is empty and res_valid is high with a nonzero res_dst_reg, wb_* are driven combinationally from res_* in the same cycle.
  - If wb_ready is also high, the entry is consumed without being written; otherwise it is pushed normally.
  - Gives 0-cycle latency.
- Not defined: no combinational path from res_* to wb_*; latency is always ≥1 cycle.

Test Plan:
- Reset, then 4 issue_valid pulses with no results → credit_avail falls to 0 after the 4th issue; a 5th issue_valid sets err_overflow.
- Issue one instruction. 5 cycles later apply res_data = 64'h0000_0003_0000_0005, res_hi_sel = 0, dst = 7, tag = 2, with wb_ready = 1 → next cycle wb_valid = 1, wb_data = 32'h5, wb_dst_reg = 7, wb_tag = 2. Credits return to 4.
- Same data with res_hi_sel = 1 → wb_data = 32'h3.
- Fill the FIFO with 4 results while wb_ready = 0 → occupancy = 4, credit_avail = 0, wb_* stable. Then hold wb_ready = 1 → tags drain in order 0, 1, 2, 3 over 4 cycles; occupancy ends at 0.
- Full FIFO, then push and pop in the same cycle → occupancy stays 4, no error. Result with dst_reg = 0 → not pushed, inflight decrements.
- res_valid with inflight = 0 → err_orphan = 1 and stays high until rst is asserted mid-stream. After reset: all flags 0, wb_valid = 0, credit_avail = 1.
